// File: rtl/ram_pkg.sv
// Shared constants and address-split helpers for the banked RAM.
// Address split: low bits select the bank, the remaining bits select the row.
package ram_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 20;
  localparam int DEF_DEPTH     = 786432;
  localparam int DEF_NUM_BANKS = 4;
  localparam int DEF_RD_LAT    = 1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Bank index is the low bank_bits of the word address.
  function automatic logic [31:0] bank_of(input logic [31:0] addr, input int bank_bits);
    return addr & ((32'd1 << bank_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] row_of(input logic [31:0] addr, input int bank_bits);
    return addr >> bank_bits;
  endfunction

endpackage

// File: rtl/ram_bank.sv
// One RAM bank: a single synchronous read/write port with byte-enable writes.
// Read data is registered and holds until the next read of this bank.
module ram_bank #(
  parameter int DATA_W = 16,
  parameter int ROWS   = 4,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ROW_W-1:0]  row,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [ROWS];

  // NOTE: storage and its read register carry no reset, so they map onto
  // block RAM; the parent gates rdata with its own reset-cleared valid.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem[row][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata <= mem[row];
      end
    end
  end

endmodule

// File: rtl/banked_ram.sv
// Two-port banked RAM: port A read/write with fixed priority, port B read-only.
// B stalls when it targets the same bank as an active A request.
module banked_ram
  import ram_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic                CK,
  input  logic                RST_N,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic                a_ready,
  output logic                a_rvalid,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_req,
  input  logic [ADDR_W-1:0]   b_addr,
  output logic                b_ready,
  output logic                b_rvalid,
  output logic [DATA_W-1:0]   b_rdata,
  output logic [15:0]         conflict_cnt
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROWS      = (DEPTH + NUM_BANKS - 1) / NUM_BANKS;
  localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("banked_ram: RD_LAT out of range");
  end

  logic [BANK_W-1:0] a_bank, b_bank;
  logic [ROW_W-1:0]  a_row, b_row;
  logic              a_in_range, b_in_range;
  logic              a_acc, b_acc;
  logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

  assign a_bank     = BANK_W'(bank_of(32'(a_addr), BANK_BITS));
  assign b_bank     = BANK_W'(bank_of(32'(b_addr), BANK_BITS));
  assign a_row      = ROW_W'(row_of(32'(a_addr), BANK_BITS));
  assign b_row      = ROW_W'(row_of(32'(b_addr), BANK_BITS));
  assign a_in_range = 32'(a_addr) < DEPTH_U;
  assign b_in_range = 32'(b_addr) < DEPTH_U;

  // Ready follows reset directly so the first edge after release can accept.
  assign a_ready = RST_N;
  assign b_ready = RST_N && !(a_req && (a_bank == b_bank));
  assign a_acc   = a_req && a_ready;
  assign b_acc   = b_req && b_ready;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic a_hit, b_hit;
    // Out-of-range and all-bytes-disabled writes never touch the array.
    assign a_hit = a_acc && a_in_range && (a_bank == BANK_W'(g)) && (!a_we || (|a_be));
    assign b_hit = b_acc && b_in_range && (b_bank == BANK_W'(g));

    ram_bank #(.DATA_W(DATA_W), .ROWS(ROWS)) u_bank (
      .clk   (CK),
      .en    (a_hit || b_hit),
      .we    (a_hit && a_we),
      .be    (a_be),
      .row   (a_hit ? a_row : b_row),
      .wdata (a_wdata),
      .rdata (bank_rdata[g])
    );
  end

  // First read stage: the bank's own register supplies the data.
  logic              a_v1, a_ok1, b_v1, b_ok1;
  logic [BANK_W-1:0] a_bank1, b_bank1;
  logic [DATA_W-1:0] a_d1, b_d1;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      a_v1    <= 1'b0;
      a_ok1   <= 1'b0;
      a_bank1 <= '0;
      b_v1    <= 1'b0;
      b_ok1   <= 1'b0;
      b_bank1 <= '0;
    end else begin
      a_v1    <= a_acc && !a_we;
      a_ok1   <= a_in_range;
      a_bank1 <= a_bank;
      b_v1    <= b_acc;
      b_ok1   <= b_in_range;
      b_bank1 <= b_bank;
    end
  end

  assign a_d1 = (a_v1 && a_ok1) ? bank_rdata[a_bank1] : '0;
  assign b_d1 = (b_v1 && b_ok1) ? bank_rdata[b_bank1] : '0;

  if (RD_LAT == 1) begin : g_lat1
    assign a_rvalid = a_v1;
    assign a_rdata  = a_d1;
    assign b_rvalid = b_v1;
    assign b_rdata  = b_d1;
  end else begin : g_pipe
    logic [RD_LAT-2:0] a_vq, b_vq;
    logic [DATA_W-1:0] a_dq [RD_LAT-1];
    logic [DATA_W-1:0] b_dq [RD_LAT-1];

    always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
        a_vq <= '0;
        b_vq <= '0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
          a_dq[i] <= '0;
          b_dq[i] <= '0;
        end
      end else begin
        a_vq[0] <= a_v1;
        b_vq[0] <= b_v1;
        a_dq[0] <= a_d1;
        b_dq[0] <= b_d1;
        for (int i = 1; i < RD_LAT - 1; i++) begin
          a_vq[i] <= a_vq[i-1];
          b_vq[i] <= b_vq[i-1];
          a_dq[i] <= a_dq[i-1];
          b_dq[i] <= b_dq[i-1];
        end
      end
    end

    assign a_rvalid = a_vq[RD_LAT-2];
    assign a_rdata  = a_dq[RD_LAT-2];
    assign b_rvalid = b_vq[RD_LAT-2];
    assign b_rdata  = b_dq[RD_LAT-2];
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      conflict_cnt <= '0;
    end else if (b_req && !b_ready && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_banked_ram.sv
// Directed bench for banked_ram: 4 banks, DEPTH=64 (so addr 64 aliases row 0
// of bank 0 if not range-checked), RD_LAT=3.
module tb_banked_ram;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 20;
  localparam int DEPTH     = 64;
  localparam int NUM_BANKS = 4;
  localparam int RD_LAT    = 3;

  logic              CK, RST_N;
  logic              a_req, a_we;
  logic [1:0]        a_be;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ready, a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic              b_ready, b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  logic [15:0]       conflict_cnt;

  int errors = 0;
  int checks = 0;

  banked_ram #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .NUM_BANKS(NUM_BANKS), .RD_LAT(RD_LAT)
  ) dut (
    .CK(CK), .RST_N(RST_N),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_ready(b_ready),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .conflict_cnt(conflict_cnt)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic a_write(input logic [ADDR_W-1:0] addr, input logic [15:0] data, input logic [1:0] be);
    a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data; a_be = be;
    tick();
    a_req = 1'b0; a_we = 1'b0; a_be = 2'b00;
  endtask

  task automatic a_read(input logic [ADDR_W-1:0] addr);
    a_req = 1'b1; a_we = 1'b0; a_addr = addr;
    tick();
    a_req = 1'b0;
  endtask

  task automatic b_read(input logic [ADDR_W-1:0] addr);
    b_req = 1'b1; b_addr = addr;
    tick();
    b_req = 1'b0;
  endtask

  // Called just after the accepting edge; walks the RD_LAT-cycle window.
  task automatic expect_read(input bit on_b, input logic [15:0] exp, input string tag);
    for (int i = 1; i < RD_LAT; i++) begin
      check({tag, " early rvalid"}, on_b ? b_rvalid : a_rvalid, 0);
      tick();
    end
    check({tag, " rvalid"}, on_b ? b_rvalid : a_rvalid, 1);
    check({tag, " rdata"}, on_b ? b_rdata : a_rdata, 32'(exp));
    tick();
    check({tag, " rvalid drop"}, on_b ? b_rvalid : a_rvalid, 0);
    check({tag, " rdata idle"}, on_b ? b_rdata : a_rdata, 0);
  endtask

  initial begin
    RST_N = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_be = 2'b00; a_addr = '0; a_wdata = '0;
    b_req = 1'b1; b_addr = 20'd1;

    // Reset state, with requests pending to prove nothing is accepted.
    tick(); tick();
    check("rst a_ready", a_ready, 0);
    check("rst b_ready", b_ready, 0);
    check("rst a_rvalid", a_rvalid, 0);
    check("rst b_rvalid", b_rvalid, 0);
    check("rst a_rdata", a_rdata, 0);
    check("rst b_rdata", b_rdata, 0);
    check("rst conflict_cnt", conflict_cnt, 0);
    a_req = 1'b0; b_req = 1'b0;
    RST_N = 1'b1;
    #1;
    check("post-rst a_ready", a_ready, 1);
    check("post-rst b_ready", b_ready, 1);

    // Write on the first edge after release, then B readback.
    a_write(20'd5, 16'hBEEF, 2'b11);
    b_read(20'd5);
    expect_read(1'b1, 16'hBEEF, "b rd5");

    // Byte-enable merge.
    a_write(20'd8, 16'h1234, 2'b11);
    a_write(20'd8, 16'hAB00, 2'b10);
    a_read(20'd8);
    expect_read(1'b0, 16'hAB34, "a rd8 merge");

    // be=0 write is a no-op and raises no rvalid.
    a_write(20'd8, 16'hFFFF, 2'b00);
    for (int i = 0; i < RD_LAT + 1; i++) begin
      check("be0 no rvalid", a_rvalid, 0);
      tick();
    end
    a_read(20'd8);
    expect_read(1'b0, 16'hAB34, "a rd8 after be0");

    // Same-bank conflict: A addr 4, B addr 8.
    a_write(20'd4, 16'h0444, 2'b11);
    a_req = 1'b1; a_we = 1'b0; a_addr = 20'd4;
    b_req = 1'b1; b_addr = 20'd8;
    #1;
    check("conflict b_ready", b_ready, 0);
    check("conflict a_ready", a_ready, 1);
    tick();
    a_req = 1'b0;
    check("conflict_cnt one", conflict_cnt, 1);
    #1;
    check("retry b_ready", b_ready, 1);
    tick();
    b_req = 1'b0;
    check("conflict a early", a_rvalid, 0);
    tick();
    check("conflict a rvalid", a_rvalid, 1);
    check("conflict a rdata", a_rdata, 32'h0444);
    check("conflict b early", b_rvalid, 0);
    tick();
    check("conflict a drop", a_rvalid, 0);
    check("conflict b rvalid", b_rvalid, 1);
    check("conflict b rdata", b_rdata, 32'hAB34);
    tick();
    check("conflict b drop", b_rvalid, 0);
    check("conflict_cnt held", conflict_cnt, 1);

    // Different banks: both accepted in the same cycle.
    a_req = 1'b1; a_we = 1'b0; a_addr = 20'd4;
    b_req = 1'b1; b_addr = 20'd5;
    #1;
    check("no conflict b_ready", b_ready, 1);
    tick();
    a_req = 1'b0; b_req = 1'b0;
    tick(); tick();
    check("dual a rvalid", a_rvalid, 1);
    check("dual a rdata", a_rdata, 32'h0444);
    check("dual b rvalid", b_rvalid, 1);
    check("dual b rdata", b_rdata, 32'hBEEF);
    check("dual conflict_cnt", conflict_cnt, 1);

    // Back-to-back B reads give back-to-back rvalid.
    tick();
    b_req = 1'b1; b_addr = 20'd5;
    tick();
    b_addr = 20'd8;
    tick();
    b_req = 1'b0;
    check("b2b early", b_rvalid, 0);
    tick();
    check("b2b first rvalid", b_rvalid, 1);
    check("b2b first rdata", b_rdata, 32'hBEEF);
    tick();
    check("b2b second rvalid", b_rvalid, 1);
    check("b2b second rdata", b_rdata, 32'hAB34);
    tick();
    check("b2b drop", b_rvalid, 0);

    // Out of range: read returns zero, write is discarded (would alias addr 0).
    a_write(20'd0, 16'h0A0A, 2'b11);
    b_read(20'(DEPTH));
    expect_read(1'b1, 16'h0000, "b oor read");
    a_write(20'(DEPTH), 16'hDEAD, 2'b11);
    a_read(20'd0);
    expect_read(1'b0, 16'h0A0A, "a rd0 after oor write");
    a_read(20'(DEPTH));
    expect_read(1'b0, 16'h0000, "a oor read");

    // Reset with reads in flight drops them.
    b_req = 1'b1; b_addr = 20'd5;
    tick();
    b_addr = 20'd8;
    tick();
    b_addr = 20'd4;
    RST_N = 1'b0;
    #1;
    check("midrst b_rvalid", b_rvalid, 0);
    check("midrst b_ready", b_ready, 0);
    tick();
    b_addr = 20'd0;
    tick();
    b_req = 1'b0;
    RST_N = 1'b1;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      check("dropped b_rvalid", b_rvalid, 0);
      tick();
    end
    check("post-pulse conflict_cnt", conflict_cnt, 0);

    // Held conflict saturates the counter.
    a_req = 1'b1; a_we = 1'b0; a_addr = 20'd0;
    b_req = 1'b1; b_addr = 20'd4;
    repeat (65534) tick();
    check("cnt FFFE", conflict_cnt, 32'hFFFE);
    tick();
    check("cnt FFFF", conflict_cnt, 32'hFFFF);
    repeat (4400) tick();
    check("cnt saturated", conflict_cnt, 32'hFFFF);
    a_req = 1'b0; b_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
